// File: rtl/drain_pkg.sv
// Shared types and constants for the output-buffer drain: default widths,
// FSM state encoding and the 16-bit saturation limits.
package drain_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF  = 16;
    localparam int CNT_WIDTH_DEF  = 8;

    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO holding reduced results ({last, sat, data}) between the
// output-buffer read pipeline and the downstream valid/ready stream.
module drain_skid_fifo #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: the storage is reset because the head feeds m_data directly and
    // must read as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_out_drain.sv
// Output-buffer drain: reads finished partial sums, reduces them to OUT_WIDTH
// by signed saturation or truncation, and streams them out with last/done.
module psum_out_drain
    import drain_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  out_count,
    input  logic                  sat_en,
    input  logic                  outbuf_empty,
    input  logic [DATA_WIDTH-1:0] outbuf_dout,
    output logic                  outbuf_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  m_sat,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int FW = OUT_WIDTH + 2;

    localparam logic [OUT_WIDTH-1:0] CLIP_HI = (OUT_WIDTH == OUT_WIDTH_DEF) ?
        OUT_WIDTH'(SAT_MAX) : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] CLIP_LO = (OUT_WIDTH == OUT_WIDTH_DEF) ?
        OUT_WIDTH'(SAT_MIN) : {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] LIM_HI = DATA_WIDTH'(signed'(CLIP_HI));
    localparam logic signed [DATA_WIDTH-1:0] LIM_LO = DATA_WIDTH'(signed'(CLIP_LO));

    state_t               state;
    state_t               state_nxt;
    logic                 sat_q;
    logic [CNT_WIDTH-1:0] req_left;
    logic [CNT_WIDTH-1:0] acc_left;
    logic                 rd_pend;
    logic                 rd_last;
    logic [1:0]           fifo_count;
    logic [1:0]           occ;
    logic [FW-1:0]        fifo_head;
    logic [FW-1:0]        push_word;
    logic [OUT_WIDTH-1:0] red_data;
    logic                 red_sat;
    logic                 pop;
    logic                 ren;

    assign m_valid    = (fifo_count != 2'd0);
    assign pop        = m_valid && m_ready;
    assign m_data     = fifo_head[OUT_WIDTH-1:0];
    assign m_sat      = m_valid && fifo_head[OUT_WIDTH];
    assign m_last     = m_valid && fifo_head[OUT_WIDTH+1];
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign outbuf_ren = ren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (out_count != '0) ? RUN : DONE;
            RUN:  if (pop && (acc_left == CNT_WIDTH'(1))) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q    <= 1'b0;
            req_left <= '0;
            acc_left <= '0;
        end else if ((state == IDLE) && start) begin
            sat_q    <= sat_en;
            req_left <= out_count;
            acc_left <= out_count;
        end else begin
            if (ren) req_left <= req_left - CNT_WIDTH'(1);
            if (pop) acc_left <= acc_left - CNT_WIDTH'(1);
        end
    end

    // The slot freed by this cycle's pop counts as free, which is what lets
    // a held-ready consumer see one result per cycle.
    always_comb begin
        occ = fifo_count + {1'b0, rd_pend} - {1'b0, pop};
        ren = (state == RUN) && !outbuf_empty && (req_left != '0) && (occ < 2'd2);
    end

    // Clearing rd_pend on reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            rd_pend <= ren;
            rd_last <= ren && (req_left == CNT_WIDTH'(1));
        end
    end

    always_comb begin
        red_data = outbuf_dout[OUT_WIDTH-1:0];
        red_sat  = 1'b0;
        if (sat_q) begin
            if ($signed(outbuf_dout) > LIM_HI) begin
                red_data = CLIP_HI;
                red_sat  = 1'b1;
            end else if ($signed(outbuf_dout) < LIM_LO) begin
                red_data = CLIP_LO;
                red_sat  = 1'b1;
            end
        end
    end

    assign push_word = {rd_last, red_sat, red_data};

    drain_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (push_word),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_psum_out_drain.sv
// Self-checking bench for psum_out_drain: buffer model, stream monitor and a
// behavioural reduction model driven by directed and random jobs.
module tb_psum_out_drain;
    import drain_pkg::*;

    localparam int DW = 32;
    localparam int OW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] out_count;
    logic          sat_en;
    logic          outbuf_empty;
    logic [DW-1:0] outbuf_dout = '0;
    logic          outbuf_ren;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_sat;
    logic          m_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    psum_out_drain dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .out_count    (out_count),
        .sat_en       (sat_en),
        .outbuf_empty (outbuf_empty),
        .outbuf_dout  (outbuf_dout),
        .outbuf_ren   (outbuf_ren),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sat        (m_sat),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Output-buffer model: words loaded by the stimulus, popped on each read.
    logic [DW-1:0] mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   cyc = 0;
    logic gap_en = 1'b0;
    logic gap_phase = 1'b0;
    logic ren_seen = 1'b0;

    assign outbuf_empty = (wr_ptr == rd_ptr) || gap_phase;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren_seen) begin
            outbuf_dout <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
        gap_phase <= gap_en ? ~gap_phase : 1'b0;
    end

    // Stream monitor, sampled mid-cycle.
    int            ren_cnt = 0;
    int            ren_bad = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            hs_n = 0;
    int            stab_bad = 0;
    logic [OW-1:0] got_data [0:1023];
    logic          got_sat  [0:1023];
    logic          got_last [0:1023];
    int            got_cyc  [0:1023];
    logic          hold_prev = 1'b0;
    logic [OW+1:0] prev_beat = '0;

    always @(negedge clk) begin
        ren_seen <= outbuf_ren;
        if (outbuf_ren) begin
            ren_cnt++;
            if (outbuf_empty) ren_bad++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold_prev && (!m_valid || ({m_last, m_sat, m_data} != prev_beat))) stab_bad++;
        hold_prev = m_valid && !m_ready;
        prev_beat = {m_last, m_sat, m_data};
        if (m_valid && m_ready) begin
            got_data[hs_n] = m_data;
            got_sat[hs_n]  = m_sat;
            got_last[hs_n] = m_last;
            got_cyc[hs_n]  = cyc;
            hs_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    // Reference reduction: {clipped, result} from the signed value of the word.
    function automatic logic [OW:0] ref_reduce(input logic [DW-1:0] w, input logic sat);
        longint v;
        longint hi;
        v  = longint'(signed'(w));
        hi = (longint'(1) <<< (OW - 1)) - 1;
        if (sat && (v > hi))      return {1'b1, SAT_MAX};
        if (sat && (v < -hi - 1)) return {1'b1, SAT_MIN};
        return {1'b0, w[OW-1:0]};
    endfunction

    int   j_base, j_hs, j_ren, j_done, j_cnt, j_stab, j_bad;
    logic j_sat;

    task automatic start_job(input int cnt, input logic sat);
        j_base = rd_ptr;
        j_hs   = hs_n;
        j_ren  = ren_cnt;
        j_done = done_cnt;
        j_stab = stab_bad;
        j_bad  = ren_bad;
        j_cnt  = cnt;
        j_sat  = sat;
        start     = 1'b1;
        out_count = cnt[CW-1:0];
        sat_en    = sat;
        tick();
        start = 1'b0;
    endtask

    // ready_mode 0: ready held high; 1: ready randomised each cycle.
    task automatic finish_job(input string tag, input int ready_mode);
        int budget = 0;
        logic [OW:0] exp;
        while ((done_cnt == j_done) && (budget < 400)) begin
            m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            budget++;
        end
        check({tag, " done_seen"}, 32'(budget < 400), 32'd1);
        check({tag, " busy_after_done"}, 32'(busy), 32'd0);
        repeat (3) tick();
        check({tag, " done_pulses"}, 32'(done_cnt - j_done), 32'd1);
        check({tag, " results"}, 32'(hs_n - j_hs), 32'(j_cnt));
        check({tag, " reads"}, 32'(ren_cnt - j_ren), 32'(j_cnt));
        check({tag, " read_while_empty"}, 32'(ren_bad - j_bad), 32'd0);
        check({tag, " stream_stable"}, 32'(stab_bad - j_stab), 32'd0);
        for (int i = 0; i < j_cnt; i++) begin
            exp = ref_reduce(mem[j_base + i], j_sat);
            check($sformatf("%s data[%0d]", tag, i), 32'(got_data[j_hs + i]), 32'(exp[OW-1:0]));
            check($sformatf("%s sat[%0d]", tag, i), 32'(got_sat[j_hs + i]), 32'(exp[OW]));
            check($sformatf("%s last[%0d]", tag, i), 32'(got_last[j_hs + i]), 32'(i == j_cnt - 1));
        end
        if (j_cnt > 0)
            check({tag, " done_latency"}, 32'(done_cyc - got_cyc[j_hs + j_cnt - 1]), 32'd1);
    endtask

    task automatic check_back_to_back(input string tag);
        for (int i = 1; i < j_cnt; i++)
            check($sformatf("%s gap[%0d]", tag, i), 32'(got_cyc[j_hs + i] - got_cyc[j_hs + i - 1]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] r;
        int            b;
        int            n;

        rst = 1'b1; start = 1'b0; out_count = '0; sat_en = 1'b0; m_ready = 1'b0;
        repeat (2) tick();
        check("reset ren", 32'(outbuf_ren), 32'd0);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);
        check("reset m_sat", 32'(m_sat), 32'd0);
        check("reset m_last", 32'(m_last), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Basic drain with truncation.
        load(32'h0000_0005); load(32'hFFFF_FA2C); load(32'h0001_2345);
        m_ready = 1'b1;
        start_job(3, 1'b0);
        check("basic busy_after_start", 32'(busy), 32'd1);
        finish_job("basic", 0);
        check("basic d0", 32'(got_data[j_hs]), 32'h0005);
        check("basic d1", 32'(got_data[j_hs + 1]), 32'hFA2C);
        check("basic d2", 32'(got_data[j_hs + 2]), 32'h2345);
        check_back_to_back("basic");

        // Saturation.
        load(32'h0001_2345); load(32'hFFFE_0000); load(32'hFFFF_FA2C);
        start_job(3, 1'b1);
        finish_job("sat", 0);
        check("sat d0", 32'(got_data[j_hs]), 32'h7FFF);
        check("sat s0", 32'(got_sat[j_hs]), 32'd1);
        check("sat d1", 32'(got_data[j_hs + 1]), 32'h8000);
        check("sat s1", 32'(got_sat[j_hs + 1]), 32'd1);
        check("sat d2", 32'(got_data[j_hs + 2]), 32'hFA2C);
        check("sat s2", 32'(got_sat[j_hs + 2]), 32'd0);

        // Backpressure: two reads only while ready is low, then full rate.
        for (int i = 0; i < 6; i++) load(32'h0000_1000 + 32'(i * 17));
        m_ready = 1'b0;
        start_job(6, 1'b0);
        repeat (10) tick();
        check("bp reads_held", 32'(ren_cnt - j_ren), 32'd2);
        check("bp m_valid_held", 32'(m_valid), 32'd1);
        check("bp m_data_held", 32'(m_data), 32'(mem[j_base][OW-1:0]));
        finish_job("bp", 0);
        check_back_to_back("bp");

        // Buffer empty every other cycle.
        gap_en = 1'b1;
        for (int i = 0; i < 4; i++) load(32'hFFFF_0000 | 32'(i * 255));
        start_job(4, 1'b0);
        finish_job("gaps", 0);
        gap_en = 1'b0;
        tick();

        // Zero-length job.
        start_job(0, 1'b0);
        @(negedge clk);
        check("zero done", 32'(done), 32'd1);
        check("zero ren", 32'(outbuf_ren), 32'd0);
        tick();
        check("zero busy_drop", 32'(busy), 32'd0);
        repeat (2) tick();
        check("zero reads", 32'(ren_cnt - j_ren), 32'd0);
        check("zero done_pulses", 32'(done_cnt - j_done), 32'd1);

        // start during RUN is ignored.
        for (int i = 0; i < 4; i++) load(32'h0000_0100 + 32'(i));
        m_ready = 1'b0;
        start_job(4, 1'b0);
        repeat (3) tick();
        start = 1'b1; out_count = 8'd1;
        tick();
        start = 1'b0;
        finish_job("restart", 0);

        // Reset mid-job, then a fresh two-result job.
        for (int i = 0; i < 5; i++) load(32'h0000_0A00 + 32'(i));
        m_ready = 1'b1;
        start_job(5, 1'b0);
        b = 0;
        while (!outbuf_ren && (b < 20)) begin
            @(negedge clk);
            b++;
        end
        check("rstmid first_read", 32'(b < 20), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid ren", 32'(outbuf_ren), 32'd0);
        check("rstmid m_valid", 32'(m_valid), 32'd0);
        check("rstmid m_data", 32'(m_data), 32'd0);
        check("rstmid m_last", 32'(m_last), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid done", 32'(done), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        start_job(2, 1'b0);
        finish_job("after_rst", 0);

        // Randomised jobs with random ready and random buffer gaps.
        for (int job = 0; job < 8; job++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                r = $urandom;
                case ($urandom_range(0, 3))
                    0: w = {{16{r[15]}}, r[15:0]};
                    1: begin
                        case (r[1:0])
                            2'd0: w = 32'h0000_7FFF;
                            2'd1: w = 32'h0000_8000;
                            2'd2: w = 32'hFFFF_8000;
                            default: w = 32'hFFFF_7FFF;
                        endcase
                    end
                    2: w = r;
                    default: w = {{24{r[7]}}, r[7:0]};
                endcase
                load(w);
            end
            gap_en = 1'($urandom_range(0, 1));
            start_job(n, 1'($urandom_range(0, 1)));
            finish_job($sformatf("rand%0d", job), 1);
            gap_en = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
